// File: rtl/stopwatch_bcd_if.sv
// Signal bundle between the stopwatch core and its board-side driver:
// slow clock, debounced buttons in; BCD digits and status out.
interface stopwatch_bcd_if;
    logic       slow_clk;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    modport master (
        output slow_clk, start_stop, clear, lap,
        input  tenths, sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

    modport slave (
        input  slow_clk, start_stop, clear, lap,
        output tenths, sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// MM:SS.t BCD stopwatch advanced by rising edges of a synchronised slow clock.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input logic            clk_in,
    input logic            rst_s_p,
    stopwatch_bcd_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   ss_prev_r;
    logic                   armed_r;
    logic [1:0]             state_r;
    logic                   running_r;
    logic                   wrap_r;
    logic [19:0]            live_r;
    logic [19:0]            disp_r;

    logic                   tick_s;
    logic                   ss_edge_s;
    logic                   count_en_s;
    logic [1:0]             state_nxt_s;
    logic [19:0]            live_nxt_s;
    logic [19:0]            disp_nxt_s;
    logic                   wrap_nxt_s;

    // armed_r masks the first cycle after reset so a button already held is not a press
    assign tick_s     = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign ss_edge_s  = bus.start_stop & ~ss_prev_r & armed_r;
    assign count_en_s = (state_r == RUN) & tick_s;

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk_in) begin
        if (rst_s_p) begin
            sync_r    <= '0;
            hist_r    <= 1'b0;
            ss_prev_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], bus.slow_clk};
            hist_r    <= sync_r[SYNC_STAGES-1];
            ss_prev_r <= bus.start_stop;
            armed_r   <= 1'b1;
        end
    end

    // Run/pause state transitions on start_stop presses
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (ss_edge_s) state_nxt_s = RUN;   else state_nxt_s = IDLE;
            RUN:     if (ss_edge_s) state_nxt_s = PAUSE; else state_nxt_s = RUN;
            PAUSE:   if (ss_edge_s) state_nxt_s = RUN;   else state_nxt_s = PAUSE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // BCD cascade; >= comparisons pull any corrupted digit back to zero
    always_comb begin
        live_nxt_s = live_r;
        wrap_nxt_s = 1'b0;
        if (count_en_s) begin
            if (live_r[3:0] >= 4'd9) begin
                live_nxt_s[3:0] = 4'd0;
                if (live_r[7:4] >= 4'd9) begin
                    live_nxt_s[7:4] = 4'd0;
                    if (live_r[11:8] >= 4'd5) begin
                        live_nxt_s[11:8] = 4'd0;
                        if (live_r[19:12] == MAX_BCD) begin
                            live_nxt_s[19:12] = 8'd0;
                            wrap_nxt_s        = 1'b1;
                        end else if (live_r[15:12] >= 4'd9) begin
                            live_nxt_s[15:12] = 4'd0;
                            live_nxt_s[19:16] = (live_r[19:16] >= 4'd9) ? 4'd0 : live_r[19:16] + 4'd1;
                        end else begin
                            live_nxt_s[15:12] = live_r[15:12] + 4'd1;
                        end
                    end else begin
                        live_nxt_s[11:8] = live_r[11:8] + 4'd1;
                    end
                end else begin
                    live_nxt_s[7:4] = live_r[7:4] + 4'd1;
                end
            end else begin
                live_nxt_s[3:0] = live_r[3:0] + 4'd1;
            end
        end else begin
            wrap_nxt_s = 1'b0;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_prev_r;
    logic        hold_r;
    logic [19:0] held_r;
    logic        lap_edge_s;
    logic        hold_nxt_s;
    logic [19:0] held_nxt_s;

    assign lap_edge_s = bus.lap & ~lap_prev_r & armed_r;

    // Lap hold: a pause press releases the hold ahead of a coincident lap press
    always_comb begin
        hold_nxt_s = hold_r;
        held_nxt_s = held_r;
        if ((state_r == RUN) && ss_edge_s) begin
            hold_nxt_s = 1'b0;
        end else if ((state_r == RUN) && lap_edge_s) begin
            hold_nxt_s = ~hold_r;
            held_nxt_s = live_r;
        end else begin
            hold_nxt_s = hold_r;
        end
        disp_nxt_s = hold_nxt_s ? held_nxt_s : live_nxt_s;
    end

    // Lap edge history and hold registers
    always_ff @(posedge clk_in) begin
        if (rst_s_p) begin
            lap_prev_r <= 1'b0;
            hold_r     <= 1'b0;
            held_r     <= 20'd0;
        end else if (bus.clear) begin
            lap_prev_r <= bus.lap;
            hold_r     <= 1'b0;
            held_r     <= 20'd0;
        end else begin
            lap_prev_r <= bus.lap;
            hold_r     <= hold_nxt_s;
            held_r     <= held_nxt_s;
        end
    end
`else
    logic lap_unused_s;
    assign lap_unused_s = bus.lap;
    assign disp_nxt_s   = live_nxt_s;
`endif

    // State, live counter and displayed digits; clear overrides any press
    always_ff @(posedge clk_in) begin
        if (rst_s_p) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
            live_r    <= 20'd0;
            disp_r    <= 20'd0;
        end else if (bus.clear) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
            live_r    <= 20'd0;
            disp_r    <= 20'd0;
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == RUN);
            wrap_r    <= wrap_nxt_s;
            live_r    <= live_nxt_s;
            disp_r    <= disp_nxt_s;
        end
    end

    assign bus.tenths   = disp_r[3:0];
    assign bus.sec_ones = disp_r[7:4];
    assign bus.sec_tens = disp_r[11:8];
    assign bus.min_ones = disp_r[15:12];
    assign bus.min_tens = disp_r[19:16];
    assign bus.running  = running_r;
    assign bus.wrap     = wrap_r;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd (SYNC_STAGES=2, MAX_MIN=1); expected
// displays are written as BCD hex MM_SS_t, e.g. 20'h00025 = 00:02.5.
module tb_stopwatch_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   wrap_cnt = 0;

    stopwatch_bcd_if sw_if ();

    stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MIN(1)) dut (
        .clk_in (clk),
        .rst_s_p(rst),
        .bus    (sw_if.slave)
    );

    always #10 clk = ~clk;

    logic [19:0] disp;
    assign disp = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones, sw_if.tenths};

    always @(negedge clk) if (sw_if.wrap === 1'b1) wrap_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sw_if.slow_clk = 1'b1; cyc(4);
            sw_if.slow_clk = 1'b0; cyc(4);
        end
    endtask

    task automatic press();
        sw_if.start_stop = 1'b1; cyc(2);
        sw_if.start_stop = 1'b0; cyc(1);
    endtask

    task automatic do_clear();
        sw_if.clear = 1'b1; cyc(1);
        sw_if.clear = 1'b0; cyc(1);
    endtask

    task automatic lap_press();
        sw_if.lap = 1'b1; cyc(1);
        sw_if.lap = 1'b0; cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(3);
        rst = 1'b0; cyc(1);
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL reset_digits: got %h expected %h", disp, 20'h00000); end
        tests++; if (sw_if.running !== 1'b0) begin failed++; $display("FAIL reset_running: got %b expected 0", sw_if.running); end
        tests++; if (sw_if.wrap !== 1'b0) begin failed++; $display("FAIL reset_wrap: got %b expected 0", sw_if.wrap); end
    endtask

    task automatic test_count();
        press();
        tests++; if (sw_if.running !== 1'b1) begin failed++; $display("FAIL count_running: got %b expected 1", sw_if.running); end
        sw_if.slow_clk = 1'b1; cyc(2);
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL latency_early: got %h expected %h", disp, 20'h00000); end
        cyc(1);
        tests++; if (disp !== 20'h00001) begin failed++; $display("FAIL latency_first: got %h expected %h", disp, 20'h00001); end
        cyc(1);
        sw_if.slow_clk = 1'b0; cyc(4);
        ticks(24);
        tests++; if (disp !== 20'h00025) begin failed++; $display("FAIL count_25: got %h expected %h", disp, 20'h00025); end
        tests++; if (sw_if.running !== 1'b1) begin failed++; $display("FAIL count_run_after: got %b expected 1", sw_if.running); end
        do_clear();
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL clear_digits: got %h expected %h", disp, 20'h00000); end
        tests++; if (sw_if.running !== 1'b0) begin failed++; $display("FAIL clear_running: got %b expected 0", sw_if.running); end
    endtask

    task automatic test_pause();
        press();
        ticks(13);
        tests++; if (disp !== 20'h00013) begin failed++; $display("FAIL pause_pre: got %h expected %h", disp, 20'h00013); end
        press();
        tests++; if (sw_if.running !== 1'b0) begin failed++; $display("FAIL pause_running: got %b expected 0", sw_if.running); end
        ticks(10);
        tests++; if (disp !== 20'h00013) begin failed++; $display("FAIL pause_hold: got %h expected %h", disp, 20'h00013); end
        press();
        tests++; if (sw_if.running !== 1'b1) begin failed++; $display("FAIL resume_running: got %b expected 1", sw_if.running); end
        ticks(2);
        tests++; if (disp !== 20'h00015) begin failed++; $display("FAIL resume_count: got %h expected %h", disp, 20'h00015); end
        do_clear();
    endtask

    task automatic test_clear_ss();
        press();
        ticks(74);
        tests++; if (disp !== 20'h00074) begin failed++; $display("FAIL clr_ss_pre: got %h expected %h", disp, 20'h00074); end
        press();
        sw_if.clear = 1'b1; sw_if.start_stop = 1'b1; cyc(1);
        sw_if.clear = 1'b0; cyc(2);
        sw_if.start_stop = 1'b0; cyc(1);
        ticks(3);
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL clr_ss_digits: got %h expected %h", disp, 20'h00000); end
        tests++; if (sw_if.running !== 1'b0) begin failed++; $display("FAIL clr_ss_running: got %b expected 0", sw_if.running); end
    endtask

    task automatic test_held_ss();
        sw_if.start_stop = 1'b1;
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(1000);
        ticks(2);
        tests++; if (sw_if.running !== 1'b0) begin failed++; $display("FAIL held_ss_running: got %b expected 0", sw_if.running); end
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL held_ss_digits: got %h expected %h", disp, 20'h00000); end
        sw_if.start_stop = 1'b0; cyc(2);
        press();
        tests++; if (sw_if.running !== 1'b1) begin failed++; $display("FAIL held_ss_press: got %b expected 1", sw_if.running); end
        do_clear();
    endtask

    task automatic test_wrap();
        int w0;
        press();
        w0 = wrap_cnt;
        ticks(1199);
        tests++; if (disp !== 20'h01599) begin failed++; $display("FAIL wrap_pre: got %h expected %h", disp, 20'h01599); end
        sw_if.slow_clk = 1'b1; cyc(2);
        tests++; if (sw_if.wrap !== 1'b0) begin failed++; $display("FAIL wrap_early: got %b expected 0", sw_if.wrap); end
        cyc(1);
        tests++; if (disp !== 20'h00000) begin failed++; $display("FAIL wrap_digits: got %h expected %h", disp, 20'h00000); end
        tests++; if (sw_if.wrap !== 1'b1) begin failed++; $display("FAIL wrap_pulse: got %b expected 1", sw_if.wrap); end
        cyc(1);
        tests++; if (sw_if.wrap !== 1'b0) begin failed++; $display("FAIL wrap_after: got %b expected 0", sw_if.wrap); end
        sw_if.slow_clk = 1'b0; cyc(4);
        tests++; if (wrap_cnt - w0 !== 1) begin failed++; $display("FAIL wrap_count: got %0d expected 1", wrap_cnt - w0); end
        tests++; if (sw_if.running !== 1'b1) begin failed++; $display("FAIL wrap_running: got %b expected 1", sw_if.running); end
        do_clear();
    endtask

    task automatic test_lap();
        logic [19:0] exp_held;
`ifdef STOPWATCH_LAP_EN
        exp_held = 20'h00032;
`else
        exp_held = 20'h00040;
`endif
        press();
        ticks(32);
        tests++; if (disp !== 20'h00032) begin failed++; $display("FAIL lap_pre: got %h expected %h", disp, 20'h00032); end
        lap_press();
        ticks(8);
        tests++; if (disp !== exp_held) begin failed++; $display("FAIL lap_held: got %h expected %h", disp, exp_held); end
        lap_press();
        tests++; if (disp !== 20'h00040) begin failed++; $display("FAIL lap_release: got %h expected %h", disp, 20'h00040); end
        press();
        lap_press();
        ticks(2);
        tests++; if (disp !== 20'h00040) begin failed++; $display("FAIL lap_in_pause: got %h expected %h", disp, 20'h00040); end
        do_clear();
    endtask

    initial begin
        sw_if.slow_clk   = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        test_reset();
        test_count();
        test_pause();
        test_clear_ss();
        test_held_ss();
        test_wrap();
        test_lap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
